// File: rtl/acs_butterfly_if.sv
// Butterfly-side bundle of the ACS array: predecessor metrics and branch metrics in,
// updated metrics and survivor decisions out.
interface acs_butterfly_if #(
  parameter int PM_W = 8
) ();
  logic            start;
  logic            valid_in;
  logic [PM_W-1:0] pm_in_a;
  logic [PM_W-1:0] pm_in_b;
  logic [1:0]      bm0;
  logic [1:0]      bm1;
  logic            norm;
  logic [PM_W-1:0] pm_lo;
  logic [PM_W-1:0] pm_hi;
  logic            dec_lo;
  logic            dec_hi;
  logic            dec_valid;
  logic            pm_msb;

  modport master (
    output start, valid_in, pm_in_a, pm_in_b, bm0, bm1, norm,
    input  pm_lo, pm_hi, dec_lo, dec_hi, dec_valid, pm_msb
  );

  modport slave (
    input  start, valid_in, pm_in_a, pm_in_b, bm0, bm1, norm,
    output pm_lo, pm_hi, dec_lo, dec_hi, dec_valid, pm_msb
  );
endinterface

// File: rtl/acs_butterfly.sv
// Registered add-compare-select butterfly: updates successor states j and j+32 from
// predecessors 2j and 2j+1, with saturating sums and optional half-range normalization.
module acs_butterfly #(
  parameter int PM_W    = 8,
  parameter int STATE_J = 0,
  parameter int PM_INIT = 64
) (
  input  logic          clk,
  input  logic          rst,
  acs_butterfly_if.slave bus
);

  localparam logic [PM_W-1:0] START_HI = PM_W'(PM_INIT);
  localparam logic [PM_W-1:0] START_LO = (STATE_J == 0) ? '0 : START_HI;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] pm,
                                              input logic [1:0]      bm);
    logic [PM_W:0] sum;
    sum = {1'b0, pm} + {{(PM_W-1){1'b0}}, bm};
    return sum[PM_W] ? {PM_W{1'b1}} : sum[PM_W-1:0];
  endfunction

  // Subtracting 2^(PM_W-1) is just clearing the MSB when it is set; otherwise clamp to 0.
  function automatic logic [PM_W-1:0] norm_sub(input logic [PM_W-1:0] v,
                                               input logic            en);
    if (!en)           return v;
    if (v[PM_W-1])     return {1'b0, v[PM_W-2:0]};
    return '0;
  endfunction

  state_t          state_q, state_d;
  logic [PM_W-1:0] pm_lo_q, pm_lo_d;
  logic [PM_W-1:0] pm_hi_q, pm_hi_d;
  logic            dec_lo_q, dec_lo_d;
  logic            dec_hi_q, dec_hi_d;
  logic            dec_valid_q, dec_valid_d;

  logic [PM_W-1:0] lo_a, lo_b, hi_a, hi_b;
  logic            sel_lo, sel_hi;
  logic [PM_W-1:0] new_lo, new_hi;

  // Add and compare; ties favour the 2j predecessor.
  always_comb begin
    lo_a   = sat_add(bus.pm_in_a, bus.bm0);
    lo_b   = sat_add(bus.pm_in_b, bus.bm1);
    hi_a   = sat_add(bus.pm_in_a, bus.bm1);
    hi_b   = sat_add(bus.pm_in_b, bus.bm0);
    sel_lo = (lo_b < lo_a);
    sel_hi = (hi_b < hi_a);
    new_lo = norm_sub(sel_lo ? lo_b : lo_a, bus.norm);
    new_hi = norm_sub(sel_hi ? hi_b : hi_a, bus.norm);
  end

  always_comb begin
    state_d     = state_q;
    pm_lo_d     = pm_lo_q;
    pm_hi_d     = pm_hi_q;
    dec_lo_d    = dec_lo_q;
    dec_hi_d    = dec_hi_q;
    dec_valid_d = 1'b0;
    if (bus.start) begin
      state_d  = IDLE;
      pm_lo_d  = START_LO;
      pm_hi_d  = START_HI;
      dec_lo_d = 1'b0;
      dec_hi_d = 1'b0;
    end else if (bus.valid_in) begin
      state_d     = RUN;
      pm_lo_d     = new_lo;
      pm_hi_d     = new_hi;
      dec_lo_d    = sel_lo;
      dec_hi_d    = sel_hi;
      dec_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pm_lo_q     <= START_LO;
      pm_hi_q     <= START_HI;
      dec_lo_q    <= 1'b0;
      dec_hi_q    <= 1'b0;
      dec_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pm_lo_q     <= pm_lo_d;
      pm_hi_q     <= pm_hi_d;
      dec_lo_q    <= dec_lo_d;
      dec_hi_q    <= dec_hi_d;
      dec_valid_q <= dec_valid_d;
    end
  end

  assign bus.pm_lo     = pm_lo_q;
  assign bus.pm_hi     = pm_hi_q;
  assign bus.dec_lo    = dec_lo_q;
  assign bus.dec_hi    = dec_hi_q;
  assign bus.dec_valid = dec_valid_q;
  assign bus.pm_msb    = pm_lo_q[PM_W-1] & pm_hi_q[PM_W-1];

endmodule

// File: doc/acs_butterfly.md
# acs_butterfly

Registered add-compare-select butterfly for the hard-decision rate-1/2 Viterbi decoder. It consumes the two 2-bit branch metrics produced by the branch-metric stage for one trellis butterfly. It combines them with the predecessor path metrics of states 2j and 2j+1 and holds the updated path metrics of successor states j and j+32. It also emits one survivor decision bit per successor state to the traceback memory. Thirty-two instances, one per butterfly j = 0..31, form the 64-state ACS array.

## Interface

Parameters:
- PM_W, 8, path-metric width in bits (unsigned).
- STATE_J, 0, butterfly index j (0..31); selects reset/start values.
- PM_INIT, 64, start metric for every state other than state 0.

Ports (clock and reset first):
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin new frame; reload start metrics.
- valid_in  input  1  branch metrics and predecessor metrics valid this cycle.
- pm_in_a  input  PM_W  path metric of predecessor state 2j.
- pm_in_b  input  PM_W  path metric of predecessor state 2j+1.
- bm0  input  2  branch metric, value 0..2, from path_0_bmc of the branch-metric stage.
- bm1  input  2  branch metric, value 0..2, from path_1_bmc of the branch-metric stage.
- norm  input  1  subtract 2^(PM_W-1) from both new metrics this update.
- pm_lo  output  PM_W  registered path metric of state j.
- pm_hi  output  PM_W  registered path metric of state j+32.
- dec_lo  output  1  survivor decision for state j (0 = from 2j, 1 = from 2j+1).
- dec_hi  output  1  survivor decision for state j+32.
- dec_valid  output  1  decisions valid; one pulse per accepted update.
- pm_msb  output  1  pm_lo[PM_W-1] & pm_hi[PM_W-1]; feeds the array-wide AND tree that generates norm.

## Operation

- Candidate sums, computed at PM_W+1 bits:
  - lo_a = pm_in_a + bm0, lo_b = pm_in_b + bm1.
  - hi_a = pm_in_a + bm1, hi_b = pm_in_b + bm0.
- Saturation: any candidate sum above 2^PM_W - 1 clamps to 2^PM_W - 1 before the compare.
- Compare-select: new_lo = min(lo_a, lo_b) and dec_lo = (lo_b < lo_a). The hi side is the same using hi_a and hi_b.
- Tie rule: on equal candidates, select the 2j predecessor and set the decision to 0.
- Normalization: with norm=1, subtract 2^(PM_W-1) from the selected value. A result below 0 clamps to 0. Normalization does not change the decision bits.
- Start values:
  - Start value of pm_lo = 0 when STATE_J=0, otherwise PM_INIT.
  - Start value of pm_hi = PM_INIT.
- Control priority per rising edge:
  - rst: pm_lo/pm_hi take start values; dec_lo, dec_hi and dec_valid = 0.
  - else start: same as rst. start overrides valid_in and norm in the same cycle.
  - else valid_in: registers load new_lo/new_hi/dec_lo/dec_hi; dec_valid = 1.
  - else: metrics and decisions hold; dec_valid = 0.
- norm is sampled only when valid_in=1. It is ignored otherwise.
- No backpressure: the traceback memory must accept one decision pair per valid cycle.
- The block has two states, IDLE and RUN, encoded in one flag.
  - rst or start enters IDLE.
  - The first valid_in moves the block to RUN.
  - The flag is internal only; outputs behave the same in both states.

## Timing

- Latency: one cycle. Inputs sampled with valid_in=1 at edge t appear on pm_lo, pm_hi, dec_lo, dec_hi and dec_valid after edge t.
- Throughput: one update per cycle. Back-to-back valid_in is supported.
- pm_msb is combinational from the registers and is valid in the same cycle as pm_lo/pm_hi.
- The array controller asserts norm one update after it sees the AND of all pm_msb. Saturation guarantees no wrap-around in the interim.
- Reset mid-frame: metrics return to start values on the next edge, with no partial update.

## Test plan

All scenarios use PM_W=8, PM_INIT=64.

1. Reset: assert rst for 2 cycles with STATE_J=0 -> pm_lo=0, pm_hi=64, dec_lo=0, dec_hi=0, dec_valid=0. With STATE_J=5 -> pm_lo=64, pm_hi=64.
2. Select and tie:
   - a=10, b=5, bm0=1, bm1=2, valid -> next cycle pm_lo=7, dec_lo=1, pm_hi=6, dec_hi=1, dec_valid=1.
   - Then a=10, b=12, bm0=2, bm1=0 -> pm_lo=12, dec_lo=0 (tie), pm_hi=10, dec_hi=0.
3. Saturation: a=254, b=255, bm0=2, bm1=1 -> pm_lo=255, dec_lo=0, pm_hi=255, dec_hi=0, pm_msb=1.
4. Normalization:
   - a=140, b=150, bm0=0, bm1=2, norm=1 -> pm_lo=12, pm_hi=14, both decisions 0.
   - a=20, b=30, bm0=0, bm1=0, norm=1 -> pm_lo=0, pm_hi=0.
5. Hold and start:
   - valid_in=0 for 3 cycles -> metrics unchanged, dec_valid=0.
   - start=1 together with valid_in=1 and norm=1 -> start values loaded, dec_valid=0.
6. Back-to-back stream: 16 consecutive valid cycles of random a, b, bm0, bm1 compared against a reference model -> every cycle matches, with dec_valid held high for 16 cycles.
